uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one UART transmitter (uart_tx) among N_REQ byte

---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding and index helpers for the UART transmit arbiter.
// Pure declarations: no latency, no backpressure.
package uart_tx_arbiter_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } arb_state_t;

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return wrap_add(idx, 1, n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Cyclic priority pick: first set request at or after ptr.
// Purely combinational (0 cycles); no backpressure.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    gnt_idx,
    output logic             any_req
);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        gnt_idx = '0;
        any_req = |req;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i == wrap_add(int'(ptr), off, N_REQ) && req[i]) begin
                    gnt_idx = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx among N_REQ byte requesters.
// Grant 1 cycle after req_valid, tx_dv 2 cycles after; requesters see no req_ready while another holds the lock or uart_tx is busy.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_TIMEOUT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic                         tx_dv,
    output logic [UART_BYTE_W-1:0]       tx_byte,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy,
    output logic                         lock_err
);

    localparam int GW = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_TIMEOUT - 1);

    arb_state_t             state;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          pick_idx;
    logic                   any_req;
    logic                   last_q;
    logic [CNT_W-1:0]       hold_cnt;
    logic                   sel_valid;
    logic                   sel_last;
    logic [UART_BYTE_W-1:0] sel_byte;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (GW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(grant_id) == i) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_byte  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_LOAD) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (int'(grant_id) == i) begin
                    req_ready[i] = req_valid[i];
                end
            end
        end
    end

    // Start strobe is gated by tx_busy in the same cycle so it fires on the first free cycle.
    assign tx_dv = (state == S_START) && !tx_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_byte  <= '0;
            last_q   <= 1'b0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            lock_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (sel_valid) begin
                        tx_byte <= sel_byte;
                        last_q  <= sel_last;
                        state   <= S_START;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (!tx_busy) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (last_q) begin
                            rr_ptr <= GW'(wrap_inc(int'(grant_id), N_REQ));
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Only the lock owner may continue; a stalled packet is abandoned after the timeout.
                    if (sel_valid) begin
                        state <= S_LOAD;
                    end else if ((HOLD_TIMEOUT != 0) && (hold_cnt == HOLD_LIM)) begin
                        lock_err <= 1'b1;
                        rr_ptr   <= GW'(wrap_inc(int'(grant_id), N_REQ));
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (HOLD_TIMEOUT != 0) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
